// File: rtl/hack_pc_sequencer.sv
// Hack CPU fetch/execute sequencer.
// Steps the program counter through reset, fetch, execute and update phases.
// Fetches instructions from ROM over a req/ack handshake and evaluates C-instruction jumps.
// Counts retired instructions and stops on the "jump to self" idiom.
module hack_pc_sequencer #(
   parameter int DATA_W      = 16,
   parameter int RET_W       = 32,
   parameter int HALT_DETECT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run,
   output logic              rom_req,
   input  logic              rom_ack,
   input  logic [DATA_W-1:0] rom_data,
   input  logic [DATA_W-1:0] pc_value,
   input  logic [DATA_W-1:0] jump_target,
   output logic [DATA_W-1:0] instr,
   output logic              exec_valid,
   input  logic              exec_done,
   input  logic              alu_zr,
   input  logic              alu_ng,
   output logic              pc_inc,
   output logic              pc_load,
   output logic              pc_reset,
   output logic              halted,
   output logic [RET_W-1:0]  retired
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_UPDATE = 3'd3,
      ST_PAUSED = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   state_t state_r;
   logic   halt_pend_r;
   logic   take_s;
   logic   halt_hit_s;

   // Jump decision: A-instructions never jump; C-instructions test the jjj bits against the ALU flags.
   function automatic logic jump_taken(input logic [DATA_W-1:0] ins, input logic zr, input logic ng);
      logic res;
      if (ins[DATA_W-1] == 1'b0) begin
         res = 1'b0;
      end else begin
         res = (ins[2] & ng) | (ins[1] & zr) | (ins[0] & ~zr & ~ng);
      end
      return res;
   endfunction

   // Jump and halt decisions, consumed only on the exec_done edge.
   always_comb begin
      take_s     = jump_taken(instr, alu_zr, alu_ng);
      halt_hit_s = 1'b0;
      if ((HALT_DETECT != 0) && take_s && (jump_target == pc_value)) begin
         halt_hit_s = 1'b1;
      end else begin
         halt_hit_s = 1'b0;
      end
   end

   // Sequencer state machine. All outputs are registered so that each PC control
   // is stable for a full clock period around the PC's falling-edge update.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         halt_pend_r <= 1'b0;
         rom_req     <= 1'b0;
         instr       <= {DATA_W{1'b0}};
         exec_valid  <= 1'b0;
         pc_inc      <= 1'b0;
         pc_load     <= 1'b0;
         pc_reset    <= 1'b0;
         halted      <= 1'b0;
         retired     <= {RET_W{1'b0}};
      end else begin
         // PC controls are single-cycle pulses unless re-armed below.
         pc_inc   <= 1'b0;
         pc_load  <= 1'b0;
         pc_reset <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (pc_reset) begin
                  // The clear pulse has just been presented for one full cycle.
                  rom_req <= 1'b1;
                  state_r <= ST_FETCH;
               end else if (run) begin
                  pc_reset <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_FETCH: begin
               if (rom_ack) begin
                  instr      <= rom_data;
                  rom_req    <= 1'b0;
                  exec_valid <= 1'b1;
                  state_r    <= ST_EXEC;
               end else begin
                  state_r <= ST_FETCH;
               end
            end
            ST_EXEC: begin
               if (exec_done) begin
                  exec_valid <= 1'b0;
                  state_r    <= ST_UPDATE;
                  if (halt_hit_s) begin
                     halt_pend_r <= 1'b1;
                  end else if (take_s) begin
                     pc_load <= 1'b1;
                  end else begin
                     pc_inc <= 1'b1;
                  end
               end else begin
                  state_r <= ST_EXEC;
               end
            end
            ST_UPDATE: begin
               retired <= retired + RET_W'(1);
               if (halt_pend_r) begin
                  halt_pend_r <= 1'b0;
                  halted      <= 1'b1;
                  state_r     <= ST_HALT;
               end else if (run) begin
                  rom_req <= 1'b1;
                  state_r <= ST_FETCH;
               end else begin
                  state_r <= ST_PAUSED;
               end
            end
            ST_PAUSED: begin
               if (run) begin
                  rom_req <= 1'b1;
                  state_r <= ST_FETCH;
               end else begin
                  state_r <= ST_PAUSED;
               end
            end
            ST_HALT: begin
               halted  <= 1'b1;
               state_r <= ST_HALT;
            end
            default: begin
               state_r     <= ST_IDLE;
               halt_pend_r <= 1'b0;
               rom_req     <= 1'b0;
               exec_valid  <= 1'b0;
               halted      <= 1'b0;
            end
         endcase
      end
   end

endmodule
